// File: rtl/qpsk_tx_shaper.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_tx_shaper
// Description : Baseband QPSK transmitter. Two independent PRBS9 generators
//               (x^9 + x^5 + 1) produce the I and Q bit streams at the symbol
//               rate. Each bit is mapped to a +/-1 symbol (0 -> +1, 1 -> -1)
//               and pulse-shaped by an OS-phase polyphase FIR. Since symbols
//               are +/-1, every tap is an add or subtract of a coefficient.
//               The result is truncated and saturated to S(NBT_OUT,NBF_OUT).
// Ports       : clk          system clock
//               i_reset      synchronous, active-low reset
//               i_en_rx      global enable; low freezes all state
//               i_en_os      sample-rate strobe (one per output sample)
//               i_en_rate1   symbol-rate strobe (only together with i_en_os)
//               i_coeffs     flattened coefficients, coef[j] at slice j
//               o_os_data_I  shaped I sample (registered)
//               o_os_data_Q  shaped Q sample (registered)
//               o_valid      one-cycle pulse marking a new sample pair
//               o_bit_I      last PRBS bit emitted on I
//               o_bit_Q      last PRBS bit emitted on Q
// Revision    : 1.0  initial release
// ============================================================================
module qpsk_tx_shaper #(
    parameter int       OS       = 4,
    parameter int       NUM_COEF = 24,
    parameter int       NBT_COEF = 8,
    parameter int       NBF_COEF = 7,
    parameter int       NBT_OUT  = 8,
    parameter int       NBF_OUT  = 7,
    parameter bit [8:0] SEED_I   = 9'h1AA,
    parameter bit [8:0] SEED_Q   = 9'h1FE
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_en_rx,
    input  logic                         i_en_os,
    input  logic                         i_en_rate1,
    input  logic [NUM_COEF*NBT_COEF-1:0] i_coeffs,
    output logic signed [NBT_OUT-1:0]    o_os_data_I,
    output logic signed [NBT_OUT-1:0]    o_os_data_Q,
    output logic                         o_valid,
    output logic                         o_bit_I,
    output logic                         o_bit_Q
);

    localparam int c_depth = NUM_COEF / OS;
    localparam int c_ph_w  = (OS > 1) ? $clog2(OS) : 1;
    localparam int c_idx_w = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam int c_acc_w = NBT_COEF + $clog2(c_depth) + 1;
    localparam int c_shift = NBF_COEF - NBF_OUT;

    localparam logic signed [c_acc_w-1:0] c_sat_max = c_acc_w'((1 << (NBT_OUT - 1)) - 1);
    // Bitwise inverse of 2^(n-1)-1 is -2^(n-1) in two's complement.
    localparam logic signed [c_acc_w-1:0] c_sat_min = ~c_sat_max;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [8:0]                r_lfsr_i;
    logic [8:0]                r_lfsr_q;
    logic [c_depth-1:0]        r_sym_i;   // bit 0 = +1, bit 1 = -1
    logic [c_depth-1:0]        r_sym_q;
    logic [c_ph_w-1:0]         r_phase;
    logic signed [NBT_OUT-1:0] r_data_i;
    logic signed [NBT_OUT-1:0] r_data_q;
    logic                      r_valid;
    logic                      r_bit_i;
    logic                      r_bit_q;

    // ------------------------------------------------------------------------
    // Coefficient unpacking
    // ------------------------------------------------------------------------
    logic signed [NBT_COEF-1:0] w_coef [NUM_COEF];

    genvar j;
    generate
        for (j = 0; j < NUM_COEF; j++) begin : g_coef
            assign w_coef[j] = i_coeffs[j*NBT_COEF +: NBT_COEF];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic               w_sym_step;
    logic               w_smp_step;
    logic [8:0]         w_lfsr_i_next;
    logic [8:0]         w_lfsr_q_next;
    logic [c_depth-1:0] w_sym_i_next;
    logic [c_depth-1:0] w_sym_q_next;
    logic [c_ph_w-1:0]  w_phase;
    logic [c_ph_w-1:0]  w_phase_next;

    assign w_sym_step    = i_en_rx & i_en_rate1;
    assign w_smp_step    = i_en_rx & i_en_os;
    assign w_lfsr_i_next = {r_lfsr_i[7:0], r_lfsr_i[8] ^ r_lfsr_i[4]};
    assign w_lfsr_q_next = {r_lfsr_q[7:0], r_lfsr_q[8] ^ r_lfsr_q[4]};

    // The filter sees the post-update delay line, so the symbol entering on
    // a rate1 cycle already contributes to that cycle's phase-0 sample.
    assign w_sym_i_next = w_sym_step ? {r_sym_i[c_depth-2:0], r_lfsr_i[8]} : r_sym_i;
    assign w_sym_q_next = w_sym_step ? {r_sym_q[c_depth-2:0], r_lfsr_q[8]} : r_sym_q;

    // A rate1 strobe forces phase 0; otherwise the counter free-runs and
    // wraps naturally because its width is exactly log2(OS).
    assign w_phase      = i_en_rate1 ? '0 : r_phase;
    assign w_phase_next = w_phase + c_ph_w'(1);

    // ------------------------------------------------------------------------
    // Polyphase FIR: one add/subtract per delay-line entry
    // ------------------------------------------------------------------------
    logic signed [c_acc_w-1:0] w_acc_i;
    logic signed [c_acc_w-1:0] w_acc_q;
    logic [c_idx_w-1:0]        w_idx;

    always_comb begin
        w_acc_i = '0;
        w_acc_q = '0;
        w_idx   = '0;
        for (int k = 0; k < c_depth; k++) begin
            w_idx   = c_idx_w'(k * OS) + c_idx_w'(w_phase);
            w_acc_i = w_sym_i_next[k] ? (w_acc_i - c_acc_w'(w_coef[w_idx]))
                                      : (w_acc_i + c_acc_w'(w_coef[w_idx]));
            w_acc_q = w_sym_q_next[k] ? (w_acc_q - c_acc_w'(w_coef[w_idx]))
                                      : (w_acc_q + c_acc_w'(w_coef[w_idx]));
        end
    end

    // Truncate surplus fractional bits, then clamp to the output range.
    function automatic logic signed [NBT_OUT-1:0] f_sat(input logic signed [c_acc_w-1:0] a);
        logic signed [c_acc_w-1:0] v_sh;
        v_sh = a >>> c_shift;
        if (v_sh > c_sat_max) begin
            return c_sat_max[NBT_OUT-1:0];
        end else if (v_sh < c_sat_min) begin
            return c_sat_min[NBT_OUT-1:0];
        end else begin
            return v_sh[NBT_OUT-1:0];
        end
    endfunction

    logic signed [NBT_OUT-1:0] w_out_i;
    logic signed [NBT_OUT-1:0] w_out_q;

    assign w_out_i = f_sat(w_acc_i);
    assign w_out_q = f_sat(w_acc_q);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_lfsr_i <= SEED_I;
            r_lfsr_q <= SEED_Q;
            r_sym_i  <= '0;
            r_sym_q  <= '0;
            r_phase  <= '0;
            r_data_i <= '0;
            r_data_q <= '0;
            r_valid  <= 1'b0;
            r_bit_i  <= 1'b0;
            r_bit_q  <= 1'b0;
        end else begin
            r_valid <= w_smp_step;
            if (w_sym_step) begin
                r_lfsr_i <= w_lfsr_i_next;
                r_lfsr_q <= w_lfsr_q_next;
                r_sym_i  <= w_sym_i_next;
                r_sym_q  <= w_sym_q_next;
                r_bit_i  <= r_lfsr_i[8];
                r_bit_q  <= r_lfsr_q[8];
            end
            if (w_smp_step) begin
                r_phase  <= w_phase_next;
                r_data_i <= w_out_i;
                r_data_q <= w_out_q;
            end
        end
    end

    assign o_os_data_I = r_data_i;
    assign o_os_data_Q = r_data_q;
    assign o_valid     = r_valid;
    assign o_bit_I     = r_bit_i;
    assign o_bit_Q     = r_bit_q;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_tx_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpsk_tx_shaper
// Description : Directed self-checking bench for qpsk_tx_shaper.
// Revision    : 1.0  initial release
// ============================================================================
module tb_qpsk_tx_shaper;

    localparam int NUM_COEF = 24;
    localparam int NBT_COEF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         i_reset    = 1'b1;
    logic                         i_en_rx    = 1'b1;
    logic                         i_en_os    = 1'b0;
    logic                         i_en_rate1 = 1'b0;
    logic [NUM_COEF*NBT_COEF-1:0] i_coeffs   = '0;
    logic signed [7:0]            o_os_data_I;
    logic signed [7:0]            o_os_data_Q;
    logic                         o_valid;
    logic                         o_bit_I;
    logic                         o_bit_Q;

    int total = 0;
    int bad   = 0;

    qpsk_tx_shaper dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_en_rx     (i_en_rx),
        .i_en_os     (i_en_os),
        .i_en_rate1  (i_en_rate1),
        .i_coeffs    (i_coeffs),
        .o_os_data_I (o_os_data_I),
        .o_os_data_Q (o_os_data_Q),
        .o_valid     (o_valid),
        .o_bit_I     (o_bit_I),
        .o_bit_Q     (o_bit_Q)
    );

    // Golden PRBS9 step, x^9 + x^5 + 1.
    function automatic logic [8:0] prbs_next(input logic [8:0] r);
        return {r[7:0], r[8] ^ r[4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic r1);
        i_en_os    = 1'b1;
        i_en_rate1 = r1;
        tick();
        i_en_os    = 1'b0;
        i_en_rate1 = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
    endtask

    task automatic set_all_coef(input logic [7:0] v);
        for (int j = 0; j < NUM_COEF; j++) i_coeffs[j*NBT_COEF +: NBT_COEF] = v;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        i_en_os = 1'b1;
        i_en_rate1 = 1'b1;
        set_all_coef(8'h7F);
        do_reset();
        i_en_os = 1'b0;
        i_en_rate1 = 1'b0;
        total++;
        if ({o_valid, o_bit_I, o_bit_Q, o_os_data_I, o_os_data_Q} !== 19'd0) begin
            bad++;
            $display("FAIL reset: got v=%b bI=%b bQ=%b I=%0d Q=%0d, need all 0",
                     o_valid, o_bit_I, o_bit_Q, o_os_data_I, o_os_data_Q);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_impulse();
        int   exp_i [3] = '{-64, -64, 64};
        int   exp_q [3] = '{-64, -64, -64};
        logic eb_i  [3] = '{1'b1, 1'b1, 1'b0};
        logic eb_q  [3] = '{1'b1, 1'b1, 1'b1};
        int   nvalid = 0;
        set_all_coef(8'h00);
        for (int j = 0; j < 4; j++) i_coeffs[j*NBT_COEF +: NBT_COEF] = 8'h40;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            for (int ph = 0; ph < 4; ph++) begin
                strobe(ph == 0);
                if (o_valid === 1'b1) nvalid++;
                total++;
                if (o_valid !== 1'b1 || o_bit_I !== eb_i[s] || o_bit_Q !== eb_q[s] ||
                    o_os_data_I !== 8'(exp_i[s]) || o_os_data_Q !== 8'(exp_q[s])) begin
                    bad++;
                    $display("FAIL impulse s=%0d ph=%0d: got v=%b bI=%b bQ=%b I=%0d Q=%0d, need v=1 bI=%b bQ=%b I=%0d Q=%0d",
                             s, ph, o_valid, o_bit_I, o_bit_Q, o_os_data_I, o_os_data_Q,
                             eb_i[s], eb_q[s], exp_i[s], exp_q[s]);
                end
                tick();
                if (o_valid === 1'b1) nvalid++;
                total++;
                if (o_valid !== 1'b0 || o_os_data_I !== 8'(exp_i[s])) begin
                    bad++;
                    $display("FAIL impulse_idle s=%0d ph=%0d: got v=%b I=%0d, need v=0 I=%0d",
                             s, ph, o_valid, o_os_data_I, exp_i[s]);
                end
            end
        end
        total++;
        if (nvalid != 12) begin
            bad++;
            $display("FAIL impulse_valid_count: got %0d, need 12", nvalid);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_saturation();
        set_all_coef(8'h7F);
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            strobe(1'b0);
            total++;
            if (o_os_data_I !== 8'sd127 || o_os_data_Q !== 8'sd127) begin
                bad++;
                $display("FAIL sat_pos ph=%0d: got I=%0d Q=%0d, need 127", ph, o_os_data_I, o_os_data_Q);
            end
        end
        // Coefficients change between strobes; the next strobe uses the new set.
        set_all_coef(8'h80);
        for (int ph = 0; ph < 4; ph++) begin
            strobe(1'b0);
            total++;
            if (o_os_data_I !== -8'sd128 || o_os_data_Q !== -8'sd128) begin
                bad++;
                $display("FAIL sat_neg ph=%0d: got I=%0d Q=%0d, need -128", ph, o_os_data_I, o_os_data_Q);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_phase();
        int exp_v [6] = '{0, 16, 32, 0, 0, 16};
        set_all_coef(8'h00);
        i_coeffs[1*NBT_COEF +: NBT_COEF] = 8'h10;
        i_coeffs[2*NBT_COEF +: NBT_COEF] = 8'h20;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            strobe(1'b0);
            total++;
            if (o_os_data_I !== 8'(exp_v[n]) || o_os_data_Q !== 8'(exp_v[n])) begin
                bad++;
                $display("FAIL phase n=%0d: got I=%0d Q=%0d, need %0d", n, o_os_data_I, o_os_data_Q, exp_v[n]);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_freeze();
        // Distinct per-phase taps on delay-line entry 0 expose phase and sign.
        logic r1s   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int   exp_i [6] = '{-32, -48, -8, -16, 8, 16};
        int   exp_q [6] = '{-32, -48, -8, -16, -8, -16};
        logic eb_i  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        set_all_coef(8'h00);
        i_coeffs[0*NBT_COEF +: NBT_COEF] = 8'h08;
        i_coeffs[1*NBT_COEF +: NBT_COEF] = 8'h10;
        i_coeffs[2*NBT_COEF +: NBT_COEF] = 8'h20;
        i_coeffs[3*NBT_COEF +: NBT_COEF] = 8'h30;
        do_reset();
        strobe(1'b1);
        strobe(1'b0);
        total++;
        if (o_os_data_I !== -8'sd16 || o_os_data_Q !== -8'sd16 || o_bit_I !== 1'b1) begin
            bad++;
            $display("FAIL freeze_pre: got I=%0d Q=%0d bI=%b, need -16 -16 1", o_os_data_I, o_os_data_Q, o_bit_I);
        end
        i_en_rx = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_en_os    = 1'b1;
            i_en_rate1 = (c % 4 == 0);
            tick();
            total++;
            if (o_valid !== 1'b0 || o_os_data_I !== -8'sd16 || o_os_data_Q !== -8'sd16 ||
                o_bit_I !== 1'b1 || o_bit_Q !== 1'b1) begin
                bad++;
                $display("FAIL freeze c=%0d: got v=%b I=%0d Q=%0d bI=%b bQ=%b, need v=0 I=-16 Q=-16 bI=1 bQ=1",
                         c, o_valid, o_os_data_I, o_os_data_Q, o_bit_I, o_bit_Q);
            end
        end
        i_en_os    = 1'b0;
        i_en_rate1 = 1'b0;
        i_en_rx    = 1'b1;
        for (int n = 0; n < 6; n++) begin
            strobe(r1s[n]);
            total++;
            if (o_valid !== 1'b1 || o_os_data_I !== 8'(exp_i[n]) || o_os_data_Q !== 8'(exp_q[n]) ||
                o_bit_I !== eb_i[n]) begin
                bad++;
                $display("FAIL freeze_resume n=%0d: got v=%b I=%0d Q=%0d bI=%b, need v=1 I=%0d Q=%0d bI=%b",
                         n, o_valid, o_os_data_I, o_os_data_Q, o_bit_I, exp_i[n], exp_q[n], eb_i[n]);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic run_symbols(input int nsym, inout logic [8:0] ri, inout logic [8:0] rq, input string tag);
        logic bi;
        logic bq;
        for (int s = 0; s < nsym; s++) begin
            bi = ri[8];
            bq = rq[8];
            ri = prbs_next(ri);
            rq = prbs_next(rq);
            for (int ph = 0; ph < 4; ph++) begin
                strobe(ph == 0);
                total++;
                if (o_bit_I !== bi || o_bit_Q !== bq ||
                    o_os_data_I !== (bi ? -8'sd64 : 8'sd64) ||
                    o_os_data_Q !== (bq ? -8'sd64 : 8'sd64)) begin
                    bad++;
                    $display("FAIL %s s=%0d ph=%0d: got bI=%b bQ=%b I=%0d Q=%0d, need bI=%b bQ=%b",
                             tag, s, ph, o_bit_I, o_bit_Q, o_os_data_I, o_os_data_Q, bi, bq);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [8:0] ri;
        logic [8:0] rq;
        set_all_coef(8'h00);
        for (int j = 0; j < 4; j++) i_coeffs[j*NBT_COEF +: NBT_COEF] = 8'h40;
        do_reset();
        ri = 9'h1AA;
        rq = 9'h1FE;
        run_symbols(5, ri, rq, "prerun");
        i_reset    = 1'b0;
        i_en_os    = 1'b1;
        i_en_rate1 = 1'b1;
        tick();
        i_reset    = 1'b1;
        i_en_os    = 1'b0;
        i_en_rate1 = 1'b0;
        total++;
        if ({o_valid, o_bit_I, o_bit_Q, o_os_data_I, o_os_data_Q} !== 19'd0) begin
            bad++;
            $display("FAIL midrun_reset: got v=%b bI=%b bQ=%b I=%0d Q=%0d, need all 0",
                     o_valid, o_bit_I, o_bit_Q, o_os_data_I, o_os_data_Q);
        end
        strobe(1'b1);
        total++;
        if (o_bit_I !== 1'b1) begin
            bad++;
            $display("FAIL midrun_first_bit: got bI=%b, need 1", o_bit_I);
        end
        // Rewind with a short run from the seeds after another reset.
        do_reset();
        ri = 9'h1AA;
        rq = 9'h1FE;
        run_symbols(4, ri, rq, "postrun");
    endtask

    // ------------------------------------------------------------------------
    initial begin
        tick();
        test_reset();
        test_impulse();
        test_saturation();
        test_phase();
        test_freeze();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
